// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction queue between fetch stage 1 and decode/dispatch.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid, req_pc        outstanding imem request and its PC
//   imem_resp, imem_rdata    imem response strobe and instruction
//   flush                    discard queue, skid and the in-flight response
//   rob_full, rs_full        dispatch back-pressure
//   out_valid/out_pc/out_inst  show-ahead head entry
//   fetch_stall              fetch stage 1 must hold its PC and request
//   count                    queue occupancy, skid excluded
module fetch_buffer #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic [PC_W-1:0]            req_pc,
    input  logic                       imem_resp,
    input  logic [INST_W-1:0]          imem_rdata,
    input  logic                       flush,
    input  logic                       rob_full,
    input  logic                       rs_full,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INST_W-1:0]          out_inst,
    output logic                       fetch_stall,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              skid_valid_q, skid_valid_d, drop_next_q, drop_next_d;
    logic [PC_W-1:0]   skid_pc_q;
    logic [INST_W-1:0] skid_inst_q;
    logic              deq, room, acc, enq, skid_load;
    assign out_valid   = count_q != '0;
    assign out_pc      = mem_pc[head_q];
    assign out_inst    = mem_inst[head_q];
    assign count       = count_q;
    assign deq         = out_valid && !rob_full && !rs_full;
    assign room        = (count_q != FULL) || deq;
    assign acc         = imem_resp && req_valid && !drop_next_q;
    // The skid entry is older than any new response, so it always enqueues first.
    assign enq         = room && (skid_valid_q || acc);
    assign skid_load   = acc && (!room || skid_valid_q);
    assign fetch_stall = (req_valid && !imem_resp) || skid_valid_q || (count_q == FULL && !deq);
    always_comb begin
        head_d       = flush ? '0 : head_q + AW'(deq);
        tail_d       = flush ? '0 : tail_q + AW'(enq);
        count_d      = flush ? '0 : count_q + CW'(enq) - CW'(deq);
        skid_valid_d = !flush && (skid_load || (skid_valid_q && !room));
        // A request still outstanding at flush returns wrong-path data; swallow it.
        drop_next_d  = flush ? (req_valid && !imem_resp) : (drop_next_q && !imem_resp);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            skid_valid_q <= 1'b0;
            drop_next_q  <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            skid_valid_q <= skid_valid_d;
            drop_next_q  <= drop_next_d;
        end
    end
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            mem_pc[tail_q]   <= skid_valid_q ? skid_pc_q : req_pc;
            mem_inst[tail_q] <= skid_valid_q ? skid_inst_q : imem_rdata;
        end
        if (skid_load && !flush) begin
            skid_pc_q   <= req_pc;
            skid_inst_q <= imem_rdata;
        end
    end
    a_no_resp_when_skid: assert property (@(posedge clk) disable iff (rst) !(imem_resp && skid_valid_q));
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed self-checking bench for fetch_buffer.
module tb_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, imem_resp = 1'b0, flush = 1'b0, rob_full = 1'b0, rs_full = 1'b0;
    logic [31:0] req_pc = '0, imem_rdata = '0;
    logic        out_valid, fetch_stall;
    logic [31:0] out_pc, out_inst;
    logic [3:0]  count;
    int          checks = 0, failures = 0;

    fetch_buffer #(.DEPTH(8), .PC_W(32), .INST_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata), .flush(flush),
        .rob_full(rob_full), .rs_full(rs_full), .out_valid(out_valid),
        .out_pc(out_pc), .out_inst(out_inst), .fetch_stall(fetch_stall), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic rs, input logic [31:0] pc);
        req_valid  = rv;
        imem_resp  = rs;
        req_pc     = pc;
        imem_rdata = inst_of(pc);
    endtask

    task automatic push(input logic [31:0] pc);
        drive(1'b1, 1'b1, pc);
        tick();
    endtask

    initial begin
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_stall", fetch_stall, 0);
        tick();
        rst = 1'b0;

        // streaming: one response per cycle, head lags one cycle, count stays 1
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, 32'h1000 + 32'(4 * k));
            #1;
            chk("stream_stall", fetch_stall, 0);
            tick();
            chk("stream_pc", out_pc, 32'h1000 + 32'(4 * k));
            chk("stream_cnt", count, 1);
        end
        drive(1'b0, 1'b0, '0);
        tick();
        chk("stream_drain", count, 0);

        // fill 8 with dispatch blocked, ninth goes to skid, then drain in order
        rs_full = 1'b1;
        for (int k = 0; k < 8; k++) push(32'h4000 + 32'(4 * k));
        drive(1'b0, 1'b0, '0);
        #1;
        chk("fill_cnt", count, 8);
        chk("fill_stall", fetch_stall, 1);
        push(32'h4020);
        drive(1'b0, 1'b0, '0);
        #1;
        chk("skid_cnt", count, 8);
        chk("skid_stall", fetch_stall, 1);
        rs_full = 1'b0;
        #1;
        chk("skid_stall_deq", fetch_stall, 1);
        for (int i = 0; i < 9; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_pc", out_pc, 32'h4000 + 32'(4 * i));
            chk("drain_inst", out_inst, inst_of(32'h4000 + 32'(4 * i)));
            tick();
            if (i == 0) chk("skid_stall_drop", fetch_stall, 0);
        end
        chk("drain_cnt", count, 0);
        chk("drain_valid_end", out_valid, 0);

        // full push+pop from pointers at 0: tail wraps onto the head slot
        rst = 1'b1;
        #1;
        rst = 1'b0;
        rs_full = 1'b1;
        for (int k = 0; k < 8; k++) push(32'h5000 + 32'(4 * k));
        rs_full = 1'b0;
        push(32'h5020);
        drive(1'b0, 1'b0, '0);
        #1;
        chk("pp_cnt", count, 8);
        for (int i = 1; i < 9; i++) begin
            chk("pp_pc", out_pc, 32'h5000 + 32'(4 * i));
            chk("pp_inst", out_inst, inst_of(32'h5000 + 32'(4 * i)));
            tick();
        end
        chk("pp_empty", count, 0);

        // flush with an outstanding request: next response dropped, following kept
        rs_full = 1'b1;
        push(32'h7000);
        push(32'h7004);
        drive(1'b1, 1'b0, 32'h2000);
        flush = 1'b1;
        #1;
        chk("fl_stall", fetch_stall, 1);
        tick();
        flush = 1'b0;
        chk("fl_cnt", count, 0);
        chk("fl_valid", out_valid, 0);
        push(32'h2000);
        chk("fl_drop", count, 0);
        push(32'h3000);
        drive(1'b0, 1'b0, '0);
        #1;
        chk("fl_keep_cnt", count, 1);
        chk("fl_keep_pc", out_pc, 32'h3000);
        rs_full = 1'b0;
        tick();
        chk("fl_drain", count, 0);

        // flush while full with skid occupied
        rs_full = 1'b1;
        for (int k = 0; k < 9; k++) push(32'h8000 + 32'(4 * k));
        drive(1'b0, 1'b0, '0);
        #1;
        chk("fs_cnt", count, 8);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rs_full = 1'b0;
        #1;
        chk("fs_cnt0", count, 0);
        chk("fs_valid", out_valid, 0);
        chk("fs_stall", fetch_stall, 0);
        push(32'h6000);
        drive(1'b0, 1'b0, '0);
        #1;
        chk("fs_after_pc", out_pc, 32'h6000);
        tick();

        // asynchronous reset mid-cycle, no clock edge in between
        rs_full = 1'b1;
        for (int k = 0; k < 5; k++) push(32'h9000 + 32'(4 * k));
        drive(1'b0, 1'b0, '0);
        #1;
        chk("ar_cnt5", count, 5);
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_cnt", count, 0);
        #1;
        rst = 1'b0;
        rs_full = 1'b0;
        tick();
        chk("ar_after", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
